// File: rtl/fir_mac_sequencer_if.sv
// Sample handshake and FIR datapath control bundle for the shared-MAC sequencer.
// The master modport is the sequencer; the slave modport is the source/datapath side.
interface fir_mac_sequencer_if #(
  parameter int unsigned ADDR_W = 2
) ();
  logic              sample_valid;
  logic              sample_ready;
  logic              wr_en;
  logic              wr_zero;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] coef_addr;
  logic              acc_clr;
  logic              acc_en;
  logic              out_valid;

  modport master (
    input  sample_valid,
    output sample_ready, wr_en, wr_zero, wr_addr, rd_addr, coef_addr, acc_clr, acc_en, out_valid
  );

  modport slave (
    output sample_valid,
    input  sample_ready, wr_en, wr_zero, wr_addr, rd_addr, coef_addr, acc_clr, acc_en, out_valid
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR controller: zero-fills the delay line, writes each accepted sample,
// then walks one shared MAC across all taps and pulses out_valid when y[n] is ready.
module fir_mac_sequencer #(
  parameter int unsigned TAPS   = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic                CLK,
  input  logic                RST,
  fir_mac_sequencer_if.master bus,
  output logic [2:0]          state_monitor
);

  typedef enum logic [2:0] {
    StClear = 3'd0,
    StIdle  = 3'd1,
    StWrite = 3'd2,
    StMac   = 3'd3,
    StDrain = 3'd4
  } state_e;

  localparam logic [ADDR_W-1:0] TapLast = ADDR_W'(TAPS - 1);
  localparam logic [ADDR_W:0]   TapsW   = (ADDR_W + 1)'(TAPS);

  state_e            state_q;
  logic [ADDR_W-1:0] head_q;
  logic [ADDR_W-1:0] k_q;
  logic              acc_en_q;
  logic              out_valid_q;
  logic [ADDR_W:0]   rd_wide;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StClear;
      head_q      <= '0;
      k_q         <= '0;
      acc_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // Product of MAC cycle k is available one cycle later (RAM/ROM read latency).
      acc_en_q    <= (state_q == StMac);
      out_valid_q <= (state_q == StDrain);
      unique case (state_q)
        StClear: begin
          if (k_q == TapLast) begin
            state_q <= StIdle;
            k_q     <= '0;
          end else begin
            k_q <= k_q + ADDR_W'(1);
          end
        end
        StIdle: begin
          if (bus.sample_valid) state_q <= StWrite;
        end
        StWrite: begin
          state_q <= StMac;
          k_q     <= '0;
        end
        StMac: begin
          if (k_q == TapLast) begin
            state_q <= StDrain;
            k_q     <= '0;
          end else begin
            k_q <= k_q + ADDR_W'(1);
          end
        end
        StDrain: begin
          state_q <= StIdle;
          head_q  <= (head_q == TapLast) ? '0 : head_q + ADDR_W'(1);
        end
        default: state_q <= StClear;
      endcase
    end
  end

  // Newest sample sits at head; tap k reads the sample k steps older, modulo TAPS.
  always_comb begin
    rd_wide = {1'b0, head_q} - {1'b0, k_q};
    if (head_q < k_q) rd_wide = rd_wide + TapsW;
  end

  always_comb begin
    bus.sample_ready = 1'b0;
    bus.wr_en        = 1'b0;
    bus.wr_zero      = 1'b0;
    bus.wr_addr      = '0;
    bus.rd_addr      = '0;
    bus.coef_addr    = '0;
    bus.acc_clr      = 1'b0;
    unique case (state_q)
      StClear: begin
        bus.wr_en   = 1'b1;
        bus.wr_zero = 1'b1;
        bus.wr_addr = k_q;
      end
      StIdle:  bus.sample_ready = ~RST;
      StWrite: begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = head_q;
        bus.acc_clr = 1'b1;
      end
      StMac: begin
        bus.rd_addr   = rd_wide[ADDR_W-1:0];
        bus.coef_addr = k_q;
      end
      default: ;
    endcase
  end

  assign bus.acc_en    = acc_en_q;
  assign bus.out_valid = out_valid_q;
  assign state_monitor = state_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer (TAPS=4): inputs driven and outputs sampled on
// the falling edge, expected values hand-derived from the cycle timing.
module tb_fir_mac_sequencer;

  logic       CLK = 1'b0;
  logic       RST;
  logic [2:0] state_monitor;
  int         n_checks = 0;
  int         n_fail   = 0;

  fir_mac_sequencer_if #(.ADDR_W(2)) bus ();

  fir_mac_sequencer #(
    .TAPS  (4),
    .ADDR_W(2)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .bus          (bus),
    .state_monitor(state_monitor)
  );

  always #5 CLK = ~CLK;

  task automatic test_reset();
    RST = 1'b1;
    bus.sample_valid = 1'b0;
    repeat (2) @(negedge CLK);
    n_checks++;
    if ({bus.sample_ready, bus.acc_en, bus.acc_clr, bus.out_valid, state_monitor} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy/acc_en/clr/ov/state %b/%b/%b/%b/%0d, want 0/0/0/0/0",
               bus.sample_ready, bus.acc_en, bus.acc_clr, bus.out_valid, state_monitor);
    end
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({state_monitor, bus.wr_en, bus.wr_zero, bus.wr_addr, bus.sample_ready, bus.acc_en,
           bus.out_valid} !== {3'd0, 1'b1, 1'b1, 2'(i), 3'b000}) begin
        n_fail++;
        $display("FAIL clear_pass[%0d]: got st/en/zero/addr/rdy/acc_en/ov %0d/%b/%b/%0d/%b/%b/%b, want 0/1/1/%0d/0/0/0",
                 i, state_monitor, bus.wr_en, bus.wr_zero, bus.wr_addr, bus.sample_ready,
                 bus.acc_en, bus.out_valid, i);
      end
      @(negedge CLK);
    end
    n_checks++;
    if ({state_monitor, bus.sample_ready, bus.wr_en, bus.wr_zero, bus.acc_en, bus.acc_clr,
         bus.out_valid, bus.wr_addr, bus.rd_addr, bus.coef_addr} !== {3'd1, 1'b1, 11'b0}) begin
      n_fail++;
      $display("FAIL idle_after_clear: got st/rdy/en/zero/acc/clr/ov %0d/%b/%b/%b/%b/%b/%b addrs %0d/%0d/%0d, want 1/1/0/0/0/0/0 addrs 0/0/0",
               state_monitor, bus.sample_ready, bus.wr_en, bus.wr_zero, bus.acc_en, bus.acc_clr,
               bus.out_valid, bus.wr_addr, bus.rd_addr, bus.coef_addr);
    end
  endtask

  task automatic test_single();
    int rd_tab[4] = '{0, 3, 2, 1};
    bus.sample_valid = 1'b1;
    n_checks++;
    if (bus.sample_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_accept: got ready %b, want 1", bus.sample_ready);
    end
    @(negedge CLK);
    bus.sample_valid = 1'b0;
    n_checks++;
    if ({state_monitor, bus.wr_en, bus.wr_zero, bus.wr_addr, bus.acc_clr, bus.acc_en,
         bus.sample_ready} !== {3'd2, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL single_write: got st/en/zero/addr/clr/acc/rdy %0d/%b/%b/%0d/%b/%b/%b, want 2/1/0/0/1/0/0",
               state_monitor, bus.wr_en, bus.wr_zero, bus.wr_addr, bus.acc_clr, bus.acc_en,
               bus.sample_ready);
    end
    @(negedge CLK);
    for (int j = 0; j < 4; j++) begin
      n_checks++;
      if ({state_monitor, bus.rd_addr, bus.coef_addr, bus.acc_en, bus.acc_clr, bus.wr_en,
           bus.out_valid, bus.sample_ready} !== {3'd3, 2'(rd_tab[j]), 2'(j), (j >= 1), 4'b0})
      begin
        n_fail++;
        $display("FAIL single_mac[%0d]: got st/rd/coef/acc/clr/wr/ov/rdy %0d/%0d/%0d/%b/%b/%b/%b/%b, want 3/%0d/%0d/%0d/0/0/0/0",
                 j, state_monitor, bus.rd_addr, bus.coef_addr, bus.acc_en, bus.acc_clr,
                 bus.wr_en, bus.out_valid, bus.sample_ready, rd_tab[j], j, (j >= 1));
      end
      @(negedge CLK);
    end
    n_checks++;
    if ({state_monitor, bus.acc_en, bus.rd_addr, bus.coef_addr, bus.out_valid, bus.wr_en} !==
        {3'd4, 1'b1, 4'b0, 2'b0}) begin
      n_fail++;
      $display("FAIL single_drain: got st/acc/rd/coef/ov/wr %0d/%b/%0d/%0d/%b/%b, want 4/1/0/0/0/0",
               state_monitor, bus.acc_en, bus.rd_addr, bus.coef_addr, bus.out_valid, bus.wr_en);
    end
    @(negedge CLK);
    n_checks++;
    if ({state_monitor, bus.out_valid, bus.sample_ready, bus.acc_en} !== {3'd1, 3'b110}) begin
      n_fail++;
      $display("FAIL single_out: got st/ov/rdy/acc %0d/%b/%b/%b, want 1/1/1/0",
               state_monitor, bus.out_valid, bus.sample_ready, bus.acc_en);
    end
    @(negedge CLK);
    n_checks++;
    if ({state_monitor, bus.out_valid} !== {3'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL single_pulse_width: got st/ov %0d/%b, want 1/0", state_monitor, bus.out_valid);
    end
  endtask

  // Valid asserted in the reset-release cycle and held: covers CLEAR blocking and
  // back-to-back acceptance with head wrap.
  task automatic test_back_to_back();
    RST = 1'b1;
    bus.sample_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    bus.sample_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({state_monitor, bus.wr_en, bus.wr_zero, bus.wr_addr, bus.sample_ready} !==
          {3'd0, 1'b1, 1'b1, 2'(i), 1'b0}) begin
        n_fail++;
        $display("FAIL b2b_clear[%0d]: got st/en/zero/addr/rdy %0d/%b/%b/%0d/%b, want 0/1/1/%0d/0",
                 i, state_monitor, bus.wr_en, bus.wr_zero, bus.wr_addr, bus.sample_ready, i);
      end
      @(negedge CLK);
    end
    for (int s = 0; s < 5; s++) begin
      int h = s % 4;
      n_checks++;
      if ({state_monitor, bus.sample_ready, bus.out_valid} !== {3'd1, 1'b1, (s > 0)}) begin
        n_fail++;
        $display("FAIL b2b_idle[%0d]: got st/rdy/ov %0d/%b/%b, want 1/1/%0d",
                 s, state_monitor, bus.sample_ready, bus.out_valid, (s > 0));
      end
      @(negedge CLK);
      n_checks++;
      if ({state_monitor, bus.wr_en, bus.wr_zero, bus.wr_addr, bus.acc_clr} !==
          {3'd2, 1'b1, 1'b0, 2'(h), 1'b1}) begin
        n_fail++;
        $display("FAIL b2b_write[%0d]: got st/en/zero/addr/clr %0d/%b/%b/%0d/%b, want 2/1/0/%0d/1",
                 s, state_monitor, bus.wr_en, bus.wr_zero, bus.wr_addr, bus.acc_clr, h);
      end
      @(negedge CLK);
      for (int j = 0; j < 4; j++) begin
        int exp_rd = (h + 4 - j) % 4;
        n_checks++;
        if ({state_monitor, bus.rd_addr, bus.coef_addr, bus.wr_en, bus.sample_ready} !==
            {3'd3, 2'(exp_rd), 2'(j), 2'b00}) begin
          n_fail++;
          $display("FAIL b2b_mac[%0d][%0d]: got st/rd/coef/wr/rdy %0d/%0d/%0d/%b/%b, want 3/%0d/%0d/0/0",
                   s, j, state_monitor, bus.rd_addr, bus.coef_addr, bus.wr_en, bus.sample_ready,
                   exp_rd, j);
        end
        @(negedge CLK);
      end
      n_checks++;
      if ({state_monitor, bus.acc_en, bus.wr_en} !== {3'd4, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL b2b_drain[%0d]: got st/acc/wr %0d/%b/%b, want 4/1/0",
                 s, state_monitor, bus.acc_en, bus.wr_en);
      end
      @(negedge CLK);
    end
    bus.sample_valid = 1'b0;
    n_checks++;
    if ({state_monitor, bus.sample_ready, bus.out_valid} !== {3'd1, 2'b11}) begin
      n_fail++;
      $display("FAIL b2b_last_out: got st/rdy/ov %0d/%b/%b, want 1/1/1",
               state_monitor, bus.sample_ready, bus.out_valid);
    end
    @(negedge CLK);
    n_checks++;
    if ({state_monitor, bus.wr_en, bus.out_valid} !== {3'd1, 2'b00}) begin
      n_fail++;
      $display("FAIL b2b_stop: got st/wr/ov %0d/%b/%b, want 1/0/0",
               state_monitor, bus.wr_en, bus.out_valid);
    end
  endtask

  // head is 1 here; a one-cycle valid pulse in the second MAC cycle must be ignored.
  task automatic test_valid_ignored();
    bus.sample_valid = 1'b1;
    @(negedge CLK);
    bus.sample_valid = 1'b0;
    n_checks++;
    if ({state_monitor, bus.wr_en, bus.wr_addr} !== {3'd2, 1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL ign_write: got st/wr/addr %0d/%b/%0d, want 2/1/1",
               state_monitor, bus.wr_en, bus.wr_addr);
    end
    @(negedge CLK);
    for (int j = 0; j < 4; j++) begin
      bus.sample_valid = (j == 1);
      n_checks++;
      if ({state_monitor, bus.wr_en, bus.sample_ready, bus.coef_addr} !== {3'd3, 2'b00, 2'(j)})
      begin
        n_fail++;
        $display("FAIL ign_mac[%0d]: got st/wr/rdy/coef %0d/%b/%b/%0d, want 3/0/0/%0d",
                 j, state_monitor, bus.wr_en, bus.sample_ready, bus.coef_addr, j);
      end
      @(negedge CLK);
    end
    bus.sample_valid = 1'b0;
    n_checks++;
    if ({state_monitor, bus.wr_en} !== {3'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL ign_drain: got st/wr %0d/%b, want 4/0", state_monitor, bus.wr_en);
    end
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({state_monitor, bus.wr_en, bus.out_valid} !== {3'd1, 1'b0, (i == 0)}) begin
        n_fail++;
        $display("FAIL ign_idle[%0d]: got st/wr/ov %0d/%b/%b, want 1/0/%0d",
                 i, state_monitor, bus.wr_en, bus.out_valid, (i == 0));
      end
      @(negedge CLK);
    end
  endtask

  // head is 2 here; reset in the second MAC cycle aborts and restarts head at 0.
  task automatic test_reset_abort();
    bus.sample_valid = 1'b1;
    @(negedge CLK);
    bus.sample_valid = 1'b0;
    n_checks++;
    if ({state_monitor, bus.wr_addr} !== {3'd2, 2'd2}) begin
      n_fail++;
      $display("FAIL abort_write: got st/addr %0d/%0d, want 2/2", state_monitor, bus.wr_addr);
    end
    @(negedge CLK);
    @(negedge CLK);
    n_checks++;
    if ({state_monitor, bus.rd_addr, bus.coef_addr, bus.acc_en} !== {3'd3, 2'd1, 2'd1, 1'b1})
    begin
      n_fail++;
      $display("FAIL abort_mac2: got st/rd/coef/acc %0d/%0d/%0d/%b, want 3/1/1/1",
               state_monitor, bus.rd_addr, bus.coef_addr, bus.acc_en);
    end
    RST = 1'b1;
    @(negedge CLK);
    n_checks++;
    if ({state_monitor, bus.acc_en, bus.out_valid, bus.acc_clr, bus.sample_ready} !== 7'b0)
    begin
      n_fail++;
      $display("FAIL abort_reset: got st/acc/ov/clr/rdy %0d/%b/%b/%b/%b, want 0/0/0/0/0",
               state_monitor, bus.acc_en, bus.out_valid, bus.acc_clr, bus.sample_ready);
    end
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({state_monitor, bus.out_valid} !== {((i < 4) ? 3'd0 : 3'd1), 1'b0}) begin
        n_fail++;
        $display("FAIL abort_no_out[%0d]: got st/ov %0d/%b, want %0d/0",
                 i, state_monitor, bus.out_valid, (i < 4) ? 0 : 1);
      end
      if (i < 4) @(negedge CLK);
    end
    bus.sample_valid = 1'b1;
    @(negedge CLK);
    bus.sample_valid = 1'b0;
    n_checks++;
    if ({state_monitor, bus.wr_en, bus.wr_addr} !== {3'd2, 1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL abort_head_restart: got st/wr/addr %0d/%b/%0d, want 2/1/0",
               state_monitor, bus.wr_en, bus.wr_addr);
    end
    @(negedge CLK);
    repeat (5) @(negedge CLK);
    n_checks++;
    if ({state_monitor, bus.out_valid} !== {3'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL abort_recover_out: got st/ov %0d/%b, want 1/1", state_monitor, bus.out_valid);
    end
  endtask

  initial begin
    RST = 1'b1;
    bus.sample_valid = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_valid_ignored();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
